// File: rtl/ifq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ifq_pkg                                                   |
// | Purpose  : Shared types and helpers for the instruction fetch queue. |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package ifq_pkg;

  // Fetch front-end operating state.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    TRAP  = 2'd1,
    HALT  = 2'd2
  } ifq_state_t;

  // One queue entry as seen by decode.
  typedef struct packed {
    logic        trap;
    logic [31:0] pc;
    logic [31:0] inst;
  } ifq_entry_t;

  // Pointer width for a power-of-two queue depth.
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage : ifq_pkg
`default_nettype wire

// File: rtl/ifq_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ifq_fifo                                                  |
// | Purpose  : DEPTH-entry circular buffer of fetch entries with push,   |
// |            pop and clear; clear wins over push and pop.              |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module ifq_fifo
  import ifq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      clear,
  input  logic                      push,
  input  ifq_entry_t                push_data,
  input  logic                      pop,
  output ifq_entry_t                head,
  output logic [ptr_w(DEPTH):0]     count,
  output logic                      empty
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  ifq_entry_t    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A simultaneous pop frees a slot, so push is legal even when full.
  assign do_push = push && ((count != FULL_CNT) || do_pop);
  assign head    = mem[rd_ptr];

  // Entry storage; contents need no reset because count gates validity.
  always_ff @(posedge i_clk) begin
    if (do_push && !clear) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; power-of-two depth lets pointers wrap freely.
  always_ff @(posedge i_clk) begin
    if (i_rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule : ifq_fifo
`default_nettype wire

// File: rtl/ifetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ifetch_queue                                              |
// | Purpose  : Instruction fetch front end. Issues sequential requests   |
// |            to an in-order multi-cycle memory, buffers returned words |
// |            with their PC and hands them to decode via valid/ready.   |
// |            Redirects flush the queue and discard in-flight words;    |
// |            a misaligned target produces a single trap entry.         |
// | Options  : IFQ_BYPASS_EN - forward a response straight to the output |
// |            when the queue is empty (zero-cycle latency).             |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module ifetch_queue
  import ifq_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int          DEPTH      = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  output logic        o_mem_req_valid,
  input  logic        i_mem_req_ready,
  output logic [31:0] o_mem_req_addr,
  input  logic        i_mem_rsp_valid,
  input  logic [31:0] i_mem_rsp_data,
  output logic        o_inst_valid,
  input  logic        i_inst_ready,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_pc,
  output logic        o_inst_trap
);

  localparam int CW = ptr_w(DEPTH) + 1;
  localparam int SW = CW + 1;

  ifq_state_t    state;
  ifq_state_t    state_next;

  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  logic [31:0]   trap_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] outstanding_next;
  logic [CW-1:0] drop;
  logic [SW-1:0] credit_sum;
  logic [31:0]   redirect_base;

  logic          req_valid;
  logic          req_fire;
  logic          rsp_ok;
  logic          keep;
  logic          bypass_ok;
  logic          bypass_taken;
  logic          out_valid;
  logic          out_pop;

  ifq_entry_t    push_entry;
  ifq_entry_t    fifo_head;
  ifq_entry_t    out_entry;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic          fifo_push;
  logic          fifo_pop;

  assign redirect_base = {i_redirect_pc[31:2], 2'b00};

  // Outstanding requests count against queue space so a response always fits.
  assign credit_sum = {1'b0, fifo_count} + {1'b0, outstanding};
  assign req_valid  = (state == FETCH) && (credit_sum < SW'(DEPTH)) && !i_redirect_valid;
  assign req_fire   = req_valid && i_mem_req_ready;

  // Responses with nothing outstanding are stray and ignored.
  assign rsp_ok           = i_mem_rsp_valid && (outstanding != '0);
  assign outstanding_next = outstanding + CW'(req_fire) - CW'(rsp_ok);
  assign keep             = rsp_ok && (drop == '0) && !i_redirect_valid;

  assign push_entry = '{trap: 1'b0, pc: rsp_pc, inst: i_mem_rsp_data};

`ifdef IFQ_BYPASS_EN
  assign bypass_ok = fifo_empty && (drop == '0) && !i_redirect_valid && rsp_ok && (state == FETCH);
`else
  assign bypass_ok = 1'b0;
`endif

  // Select what decode sees: pending trap, queue head, or a bypassed response.
  always_comb begin
    out_entry = fifo_head;
    out_valid = 1'b0;
    if (state == TRAP) begin
      out_entry = '{trap: 1'b1, pc: trap_pc, inst: 32'h0000_0000};
      out_valid = 1'b1;
    end else if (!fifo_empty) begin
      out_entry = fifo_head;
      out_valid = 1'b1;
    end else if (bypass_ok) begin
      out_entry = push_entry;
      out_valid = 1'b1;
    end
  end

  assign o_inst_valid = !i_rst && out_valid;
  assign o_inst       = out_entry.inst;
  assign o_inst_pc    = out_entry.pc;
  assign o_inst_trap  = out_entry.trap;

  assign o_mem_req_valid = !i_rst && req_valid;
  assign o_mem_req_addr  = fetch_pc;

  // A pop coinciding with a redirect is ignored; the queue is cleared anyway.
  assign out_pop      = o_inst_valid && i_inst_ready && !i_redirect_valid;
  assign bypass_taken = bypass_ok && out_pop;
  assign fifo_push    = keep && !bypass_taken;
  assign fifo_pop     = out_pop && (state != TRAP) && !fifo_empty;

  ifq_fifo #(
    .DEPTH     (DEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .clear     (i_redirect_valid),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Next state: redirects win from any state; popping the trap entry halts.
  always_comb begin
    state_next = state;
    if (i_redirect_valid) begin
      state_next = (i_redirect_pc[1:0] == 2'b00) ? FETCH : TRAP;
    end else if ((state == TRAP) && out_pop) begin
      state_next = HALT;
    end
  end

  // Fetch/response PCs and the request/discard counters.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fetch_pc    <= RESET_ADDR;
      rsp_pc      <= RESET_ADDR;
      trap_pc     <= RESET_ADDR;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (i_redirect_valid) begin
        fetch_pc <= redirect_base;
        rsp_pc   <= redirect_base;
        trap_pc  <= i_redirect_pc;
        // Everything still in flight after this cycle belongs to the old stream.
        drop     <= outstanding_next;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        if (keep)     rsp_pc   <= rsp_pc + 32'd4;
        if (rsp_ok && (drop != '0)) drop <= drop - CW'(1);
      end
    end
  end

  // Flag memory responses that arrive with nothing outstanding.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      assert (!(i_mem_rsp_valid && (outstanding == '0)));
    end
  end

endmodule : ifetch_queue
`default_nettype wire

// File: tb/tb_ifetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_ifetch_queue                                           |
// | Purpose  : Directed and random bench for ifetch_queue with an        |
// |            in-order memory model and an expected-entry scoreboard.   |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_ifetch_queue;

  typedef struct packed {
    logic        trap;
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  typedef struct packed {
    int          due;
    logic [31:0] data;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_trap;

  int          vectors     = 0;
  int          miscompares = 0;

  exp_t        sb[$];
  rsp_t        rsp_q[$];
  int          cyc         = 0;
  int          last_due    = -1;
  int          mem_lat     = 1;
  logic [31:0] exp_req_addr = 32'h0;
  logic        prev_stall  = 1'b0;
  logic        prev_redir  = 1'b0;
  logic [31:0] prev_addr   = 32'h0;
  int          phase_reqs  = 0;
  int          pops        = 0;
  logic        first_seen  = 1'b0;
  int          first_valid_cyc = -1;
  logic        capture_first = 1'b0;
  logic [31:0] first_pc    = 32'h0;

  always #5 clk = ~clk;

  ifetch_queue #(
    .RESET_ADDR       (32'h0000_0000),
    .DEPTH            (4)
  ) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .o_mem_req_valid  (mem_req_valid),
    .i_mem_req_ready  (mem_req_ready),
    .o_mem_req_addr   (mem_req_addr),
    .i_mem_rsp_valid  (mem_rsp_valid),
    .i_mem_rsp_data   (mem_rsp_data),
    .o_inst_valid     (inst_valid),
    .i_inst_ready     (inst_ready),
    .o_inst           (inst),
    .o_inst_pc        (inst_pc),
    .o_inst_trap      (inst_trap)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One clock cycle: memory model drives, DUT is sampled, scoreboard updated.
  task automatic cycle();
    int   lat;
    int   due;
    exp_t e;
    if (rsp_q.size() != 0 && rsp_q[0].due <= cyc) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = rsp_q[0].data;
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = 32'h0;
    end
    #1;
    if (prev_stall && !prev_redir && !redirect_valid) begin
      check("req_hold_valid", 32'(mem_req_valid), 32'd1);
      check("req_hold_addr", mem_req_addr, prev_addr);
    end
    if (mem_req_valid && mem_req_ready) begin
      check("req_addr", mem_req_addr, exp_req_addr);
      lat = (mem_lat > 0) ? mem_lat : int'($urandom_range(1, 4));
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      rsp_q.push_back('{due: due, data: mem_word(mem_req_addr)});
      sb.push_back('{trap: 1'b0, pc: exp_req_addr, inst: mem_word(exp_req_addr)});
      exp_req_addr = exp_req_addr + 32'd4;
      phase_reqs++;
    end
    prev_stall = mem_req_valid && !mem_req_ready;
    prev_addr  = mem_req_addr;
    prev_redir = redirect_valid;
    if (!first_seen && inst_valid) begin
      first_seen      = 1'b1;
      first_valid_cyc = cyc;
    end
    if (inst_valid && inst_ready && !redirect_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_inst", 32'(inst_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        check("inst_pc", inst_pc, e.pc);
        check("inst_word", inst, e.inst);
        check("inst_trap", 32'(inst_trap), 32'(e.trap));
        if (capture_first) begin
          first_pc      = inst_pc;
          capture_first = 1'b0;
        end
        pops++;
      end
    end
    if (redirect_valid) begin
      sb.delete();
      exp_req_addr = {redirect_pc[31:2], 2'b00};
      if (redirect_pc[1:0] != 2'b00) begin
        sb.push_back('{trap: 1'b1, pc: redirect_pc, inst: 32'h0});
      end
    end
    if (mem_rsp_valid) void'(rsp_q.pop_front());
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    cycle();
    redirect_valid = 1'b0;
    #1;
  endtask

  initial begin
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    mem_req_ready  = 1'b1;
    mem_rsp_valid  = 1'b0;
    mem_rsp_data   = 32'h0;
    inst_ready     = 1'b1;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_req_valid", 32'(mem_req_valid), 32'd0);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_req_addr", mem_req_addr, 32'h0);
    rst = 1'b0;
    cyc = 0;

    // Streaming with one-cycle memory and an always-ready consumer.
    pops = 0;
    repeat (12) cycle();
    check("first_valid_cycle", 32'(first_valid_cyc), 32'd2);
    check("stream_pops", 32'(pops), 32'd10);

    // Stalled consumer: exactly DEPTH requests, then one per pop.
    inst_ready = 1'b0;
    redirect(32'h0000_0040);
    phase_reqs = 0;
    repeat (10) cycle();
    check("full_reqs", 32'(phase_reqs), 32'd4);
    check("full_req_valid", 32'(mem_req_valid), 32'd0);
    check("full_inst_valid", 32'(inst_valid), 32'd1);
    phase_reqs = 0;
    inst_ready = 1'b1;
    cycle();
    inst_ready = 1'b0;
    repeat (6) cycle();
    check("refill_reqs", 32'(phase_reqs), 32'd1);
    check("refill_req_valid", 32'(mem_req_valid), 32'd0);

    // Three in flight, redirect to 0x100: stale words are discarded.
    inst_ready    = 1'b1;
    mem_req_ready = 1'b0;
    repeat (10) cycle();
    mem_lat       = 6;
    mem_req_ready = 1'b1;
    phase_reqs    = 0;
    repeat (3) cycle();
    check("inflight_reqs", 32'(phase_reqs), 32'd3);
    mem_req_ready = 1'b0;
    capture_first = 1'b1;
    redirect(32'h0000_0100);
    mem_req_ready = 1'b1;
    repeat (20) cycle();
    check("redir_first_pc", first_pc, 32'h0000_0100);

    // Misaligned redirect: single trap entry, then halt until redirected.
    mem_lat = 2;
    repeat (5) cycle();
    inst_ready = 1'b0;
    redirect(32'h0000_0102);
    check("trap_valid", 32'(inst_valid), 32'd1);
    check("trap_flag", 32'(inst_trap), 32'd1);
    check("trap_pc", inst_pc, 32'h0000_0102);
    check("trap_inst", inst, 32'h0);
    check("trap_no_req", 32'(mem_req_valid), 32'd0);
    repeat (2) begin
      cycle();
      check("trap_hold_no_req", 32'(mem_req_valid), 32'd0);
    end
    inst_ready = 1'b1;
    cycle();
    repeat (4) begin
      cycle();
      check("halt_inst_valid", 32'(inst_valid), 32'd0);
      check("halt_no_req", 32'(mem_req_valid), 32'd0);
    end
    redirect(32'h0000_0200);
    check("resume_req_valid", 32'(mem_req_valid), 32'd1);
    check("resume_req_addr", mem_req_addr, 32'h0000_0200);
    repeat (12) cycle();

    // Redirects on top of live responses, back to back, across the 2^32 wrap.
    mem_lat = 1;
    repeat (3) cycle();
    redirect(32'h0000_0300);
    capture_first = 1'b1;
    pops = 0;
    redirect(32'hFFFF_FFF8);
    repeat (12) cycle();
    check("wrap_first_pc", first_pc, 32'hFFFF_FFF8);
    check("wrap_progress", 32'(pops >= 4), 32'd1);

    // Random ready/latency traffic with occasional redirects.
    mem_lat = 0;
    repeat (400) begin
      mem_req_ready  = 1'($urandom_range(0, 1));
      inst_ready     = 1'($urandom_range(0, 1));
      redirect_valid = ($urandom_range(0, 29) == 0);
      redirect_pc    = {20'h0, 4'($urandom_range(0, 15)), 6'($urandom_range(0, 63)),
                        (($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00)};
      cycle();
    end
    redirect_valid = 1'b0;

    // Drain: everything expected must have been delivered.
    mem_req_ready = 1'b0;
    inst_ready    = 1'b1;
    repeat (25) cycle();
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_ifetch_queue
`default_nettype wire

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction fetch front end that replaces the combinational imem port with a request/response memory interface.
- Generates sequential fetch addresses and issues requests to a multi-cycle, in-order instruction memory.
- Buffers returned words with their PC in a small FIFO and presents them to decode through a valid/ready handshake.
- Handles redirects (taken branch/jump) by flushing the FIFO and discarding in-flight responses; a misaligned redirect target yields a trap entry.

Parameters:
- RESET_ADDR, 32'h00000000: fetch PC after reset.
- DEPTH, 4: FIFO entries and maximum outstanding requests; power of two, 2..16.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset
- i_redirect_valid  in  1  redirect fetch to i_redirect_pc this cycle
- i_redirect_pc  in  32  redirect target
- o_mem_req_valid  out  1  fetch request valid
- i_mem_req_ready  in  1  memory accepts request
- o_mem_req_addr  out  32  word-aligned fetch address
- i_mem_rsp_valid  in  1  response word valid; in order, always accepted
- i_mem_rsp_data  in  32  instruction word
- o_inst_valid  out  1  queue head valid
- i_inst_ready  in  1  consumer pops head
- o_inst  out  32  instruction word (0 when trap)
- o_inst_pc  out  32  PC of head entry
- o_inst_trap  out  1  head is a misaligned-fetch trap entry

Behaviour:
- Interface: reset i_rst, synchronous, active-high; clock i_clk.
- Reset values:
  - fetch_pc=RESET_ADDR; FIFO empty; outstanding=0; drop=0; state=FETCH.
  - o_mem_req_valid=0 and o_inst_valid=0 during the reset cycle.
  - o_mem_req_addr=RESET_ADDR.
- Counters: outstanding and drop are clog2(DEPTH)+1 bits.
- Request issue:
  - o_mem_req_valid = (state==FETCH) & (count+outstanding<DEPTH) & !i_redirect_valid.
  - o_mem_req_addr = fetch_pc, a register, so it is stable while valid and not redirected.
  - On handshake (valid&ready): fetch_pc += 4, wrapping modulo 2^32; outstanding++.
- Response:
  - Each i_mem_rsp_valid decrements outstanding.
  - If drop>0: drop-- and the word is discarded.
  - Else push {trap=0, pc=rsp_pc, inst}, where rsp_pc is a register advanced by 4 per kept response.
- Pop: o_inst_valid & i_inst_ready removes the head. Push and pop in the same cycle are legal at any count. The credit rule guarantees a push never sees a full FIFO.
- Latency: response accepted in cycle N -> o_inst_valid in cycle N+1 (registered FIFO).
- Redirect (i_redirect_valid=1 in cycle N), effective at the edge ending N:
  - FIFO is cleared; any pop in N is ignored.
  - drop = outstanding after counting any response or handshake in N. A response in N is already discarded.
  - fetch_pc = rsp_pc = {i_redirect_pc[31:2], 2'b00}.
  - If i_redirect_pc[1:0]==0: state=FETCH, and the first new request is issued in N+1.
  - Else state=TRAP: push a single entry {trap=1, pc=i_redirect_pc, inst=0}; no requests are issued.
- States:
  - FETCH: normal operation.
  - TRAP: trap entry pending; goes to HALT when that entry is popped.
  - HALT: no requests issued; leaves only on a redirect.
- Redirect in TRAP or HALT follows the same rules as in FETCH.
- A response while outstanding==0 is a protocol error: assert in sim, ignore in RTL.
- Reset mid-operation:
  - All state is cleared; the memory must be reset in the same cycle.
  - Responses after reset fall under the outstanding==0 rule.

Optional Feature:
- Macro: IFQ_BYPASS_EN.
- Defined: when the FIFO is empty, drop==0, no redirect and i_mem_rsp_valid, the response is driven combinationally onto o_inst* in the same cycle (0-cycle latency). If i_inst_ready is high it is not pushed; otherwise it is pushed as normal.
- Undefined: always registered, 1-cycle minimum latency.

Decomposition:
- Package ifq_pkg:
  - state enum {FETCH, TRAP, HALT};
  - entry struct {trap, pc[31:0], inst[31:0]};
  - function ptr_w(DEPTH) = clog2(DEPTH).
- Sub-module ifq_fifo: DEPTH x entry circular buffer with push, pop, clear, count, head. Pointers wrap modulo DEPTH. Clear has priority over push and pop.

Test Plan:
- Reset, mem ready=1, 1-cycle response latency, consumer ready=1 -> requests to 0x0,0x4,0x8…; o_inst_pc sequence 0x0,0x4,0x8 with matching words; first o_inst_valid 2 cycles after reset release.
- Consumer ready=0, DEPTH=4 -> exactly 4 requests issued, FIFO full, o_mem_req_valid=0; one pop -> exactly one new request.
- 3 outstanding, redirect to 0x100 -> next 3 responses discarded, FIFO empty; first o_inst_pc=0x100 with the 0x100 word.
- Redirect to 0x102 -> one entry trap=1, pc=0x102, inst=0; no requests issued; after pop, HALT with o_inst_valid=0; redirect to 0x200 resumes fetch at 0x200.
- Redirect coinciding with a response and a request handshake -> both counted into drop; no stale word ever reaches o_inst.
- i_mem_req_ready toggled randomly with random response delay -> o_mem_req_addr stable while valid&!ready; PC sequence continuous with no gaps or duplicates.
